multicycle_controller: RTL and testbench

Moore-style control FSM that sequences the shared multicycle RISC-V datapath (single memory, one ALU, IR/OldPC/ALUOut/Data registers) through fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal. It sits beside the ALU decoder: it drives ALUOp to the ALU decoder and every datapath mux select and enable. It stalls on a memory-ready handshake and traps on unknown opcodes.

---
 rtl/riscv_ctrl_pkg.sv | 48 ++++
 rtl/instr_imm_dec.sv | 21 ++
 rtl/multicycle_controller.sv | 154 +++++++++++++++
 tb/tb_multicycle_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path: FSM state
// encoding, major opcodes and the datapath mux / ALU control encodings.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/instr_imm_dec.sv
// Opcode -> immediate format decoder. Purely combinational so the
// single-cycle datapath can share it.
module instr_imm_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] imm_src
);

    // Pick the immediate layout; unknown opcodes fall back to I-type.
    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared-memory multicycle RISC-V datapath.
// Outputs are decoded from the state register; only IRWrite, PCUpdate and
// instr_done look at mem_ready, and PCWrite additionally looks at zero, so
// the memory handshake and branch decision take effect in the same cycle.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic       illegal,
    output logic       instr_done
);

    state_e     state_q, state_d;
    logic       pc_update;
    logic       branch;
    logic [1:0] imm_src_dec;

    instr_imm_dec u_imm_dec (
        .opcode  (opcode),
        .imm_src (imm_src_dec)
    );

    // Next-state: memory states hold until mem_ready, TRAP holds until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Per-state control decode; everything is held at 0 while reset is high.
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ALUOp      = ALUOP_ADD;
        illegal    = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    MemRead   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    IRWrite   = mem_ready;
                    pc_update = mem_ready;
                end
                DECODE: begin
                    // Precompute branch/jal target from OldPC into ALUOut.
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                MEMADR: begin
                    ALUSrcA = SRCA_RD1;
                    ALUSrcB = SRCB_IMM;
                end
                MEMREAD: begin
                    MemRead = 1'b1;
                    AdrSrc  = 1'b1;
                end
                MEMWB: begin
                    ResultSrc  = RES_DATA;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWRITE: begin
                    MemWrite   = 1'b1;
                    AdrSrc     = 1'b1;
                    instr_done = mem_ready;
                end
                EXECUTER: begin
                    ALUSrcA = SRCA_RD1;
                    ALUOp   = ALUOP_FUNCT;
                end
                EXECUTEI: begin
                    ALUSrcA = SRCA_RD1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_FUNCT;
                end
                JAL: begin
                    // Return address OldPC+4 lands in ALUOut; PC takes target.
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                    pc_update = 1'b1;
                end
                ALUWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                BEQ: begin
                    ALUSrcA    = SRCA_RD1;
                    ALUOp      = ALUOP_SUB;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                TRAP:    illegal = 1'b1;
                default: illegal = 1'b0;
            endcase
        end
    end

    assign PCWrite = pc_update | (branch & zero);
    assign ImmSrc  = reset ? IMM_I : imm_src_dec;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller. A reference model expands each
// instruction into its expected cycle-by-cycle control trace (including
// memory wait cycles) and every cycle is compared against the DUT.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] immsrc;
        logic [1:0] aluop;
        logic       illegal;
        logic       done;
    } outs_t;

    typedef struct {
        string      tag;
        logic [6:0] opc;
        logic       mr;
        logic       z;
        outs_t      o;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
    logic       illegal, instr_done;

    int n_compared = 0;
    int n_mismatched = 0;
    int n_txn = 0;
    step_t q[$];

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUOp      (ALUOp),
        .illegal    (illegal),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, illegal, instr_done};

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s got=%05h expected=%05h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] imm_model(input logic [6:0] opc);
        if (opc == SW)      return 2'b01;
        else if (opc == BQ) return 2'b10;
        else if (opc == JL) return 2'b11;
        else                return 2'b00;
    endfunction

    function automatic string opname(input logic [6:0] opc);
        case (opc)
            LW: return "lw";
            SW: return "sw";
            RT: return "rtype";
            IT: return "itype";
            BQ: return "beq";
            JL: return "jal";
            default: return "illegal";
        endcase
    endfunction

    task automatic push(input string tag, input logic [6:0] opc, input logic mr,
                        input logic z, input outs_t o);
        step_t s;
        s.tag = tag; s.opc = opc; s.mr = mr; s.z = z; s.o = o;
        q.push_back(s);
    endtask

    // Expected trace of one instruction. wf/wm = cycles of mem_ready low in
    // the fetch / data-memory access. Cycles whose behaviour must not depend
    // on mem_ready or zero get random values for those inputs.
    task automatic gen_instr(input logic [6:0] opc, input logic zb, input int wf, input int wm);
        outs_t base, o;
        logic  last;
        string n;
        n = opname(opc);
        base = '0;
        base.immsrc = imm_model(opc);
        // instruction fetch from PC, PC+4 computed alongside
        for (int i = 0; i <= wf; i++) begin
            last = (i == wf);
            o = base; o.memread = 1; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
            o.irwrite = last; o.pcwrite = last;
            push({n, ":fetch"}, opc, last, 1'($urandom), o);
        end
        o = base; o.alusrca = 2'b01; o.alusrcb = 2'b01;
        push({n, ":decode"}, opc, 1'($urandom), 1'($urandom), o);
        case (opc)
            LW, SW: begin
                o = base; o.alusrca = 2'b10; o.alusrcb = 2'b01;
                push({n, ":memadr"}, opc, 1'($urandom), 1'($urandom), o);
                for (int i = 0; i <= wm; i++) begin
                    last = (i == wm);
                    o = base; o.adrsrc = 1;
                    if (opc == LW) o.memread = 1;
                    else begin o.memwrite = 1; o.done = last; end
                    push({n, ":mem"}, opc, last, 1'($urandom), o);
                end
                if (opc == LW) begin
                    o = base; o.resultsrc = 2'b01; o.regwrite = 1; o.done = 1;
                    push({n, ":memwb"}, opc, 1'($urandom), 1'($urandom), o);
                end
            end
            RT, IT, JL: begin
                o = base;
                if (opc == JL) begin
                    o.alusrca = 2'b01; o.alusrcb = 2'b10; o.pcwrite = 1;
                end else begin
                    o.alusrca = 2'b10; o.aluop = 2'b10;
                    o.alusrcb = (opc == IT) ? 2'b01 : 2'b00;
                end
                push({n, ":exec"}, opc, 1'($urandom), 1'($urandom), o);
                o = base; o.regwrite = 1; o.done = 1;
                push({n, ":aluwb"}, opc, 1'($urandom), 1'($urandom), o);
            end
            BQ: begin
                o = base; o.alusrca = 2'b10; o.aluop = 2'b01; o.pcwrite = zb; o.done = 1;
                push({n, ":branch"}, opc, 1'($urandom), zb, o);
            end
            default: begin
                for (int i = 0; i < 10; i++) begin
                    o = base; o.illegal = 1;
                    push({n, ":trap"}, opc, 1'($urandom), 1'($urandom), o);
                end
            end
        endcase
    endtask

    // Drive each queued cycle at the falling edge and compare mid-cycle.
    task automatic run_queue();
        step_t s;
        int    cycles;
        string nm;
        cycles = 0;
        nm = (q.size() > 0) ? opname(q[0].opc) : "none";
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            reset = 0; opcode = s.opc; mem_ready = s.mr; zero = s.z;
            #1;
            check(s.tag, obs, s.o);
            cycles++;
        end
        n_txn++;
        $display("txn %0d: %s, %0d cycles", n_txn, nm, cycles);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1; opcode = 7'($urandom); mem_ready = 1'($urandom); zero = 1'($urandom);
            #1;
            check("reset", obs, '0);
        end
    endtask

    function automatic logic [6:0] rand_valid();
        case ($urandom_range(0, 5))
            0: return LW;
            1: return SW;
            2: return RT;
            3: return IT;
            4: return BQ;
            default: return JL;
        endcase
    endfunction

    initial begin
        logic [6:0] opc;
        do_reset(2);

        // directed cases
        gen_instr(LW, 0, 0, 0); run_queue();
        gen_instr(SW, 0, 0, 2); run_queue();
        gen_instr(BQ, 1, 0, 0); run_queue();
        gen_instr(BQ, 0, 1, 0); run_queue();
        gen_instr(JL, 0, 0, 0); run_queue();
        gen_instr(RT, 0, 0, 0); run_queue();
        gen_instr(IT, 0, 2, 0); run_queue();

        // illegal opcode traps, then reset recovers
        gen_instr(7'b0000000, 0, 0, 0); run_queue();
        do_reset(1);
        gen_instr(RT, 0, 0, 0); run_queue();

        // reset while a load waits in MEMREAD: no writeback may follow
        gen_instr(LW, 0, 0, 3);
        while (q.size() > 5) void'(q.pop_back());
        run_queue();
        do_reset(1);
        gen_instr(LW, 0, 0, 0); run_queue();

        // randomized instruction stream
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                opc = 7'($urandom);
                if (opc == LW || opc == SW || opc == RT || opc == IT || opc == BQ || opc == JL)
                    opc = 7'b1111111;
                gen_instr(opc, 0, $urandom_range(0, 2), 0);
                run_queue();
                do_reset($urandom_range(1, 2));
            end else begin
                gen_instr(rand_valid(), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
                run_queue();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
